obi_mgr_be: RTL and testbench

- Byte-enabled OBI manager that sits directly upstream of obi_slave_be.
- Converts a simple valid/ready command interface (address, access size, right-aligned write data) into single OBI A-channel transactions with generated byte enables.
- Collects the R-channel reply and returns right-aligned, zero-extended read data plus an error flag on a valid/ready response interface.
- One outstanding transaction at a time; misaligned accesses are rejected locally; lost responses are caught by an optional timeout.

---
 rtl/obi_mgr_pkg.sv | 34 +++
 rtl/obi_be_align.sv | 54 +++++
 rtl/obi_mgr_be.sv | 176 +++++++++++++++++
 tb/tb_obi_mgr_be.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_mgr_pkg.sv
`default_nettype none
// ============================================================================
// Package  : obi_mgr_pkg
// Brief    : Shared types and alignment helper for OBI byte-enabled managers
// Revision : 1.0
// ============================================================================
package obi_mgr_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'd0,
        SIZE_H   = 2'd1,
        SIZE_W   = 2'd2,
        SIZE_RSV = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        RESP = 3'd2,
        ERR  = 3'd3,
        DONE = 3'd4
    } mgr_state_e;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size_e'(size))
            SIZE_B:  return 1'b1;
            SIZE_H:  return ~off[0];
            SIZE_W:  return (off == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/obi_be_align.sv
`default_nettype none
// ============================================================================
// Module   : obi_be_align
// Brief    : Byte-enable generation, write lane shift and read extraction
// Revision : 1.0
// ============================================================================
module obi_be_align
    import obi_mgr_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [4:0]  w_shamt;
    logic [31:0] w_lane_mask;
    logic [31:0] w_size_mask;

    assign w_shamt = {i_off, 3'b000};

    always_comb begin
        o_be        = 4'b0000;
        w_size_mask = 32'h0000_0000;
        case (size_e'(i_size))
            SIZE_B: begin
                o_be        = 4'b0001 << i_off;
                w_size_mask = 32'h0000_00FF;
            end
            SIZE_H: begin
                o_be        = 4'b0011 << i_off;
                w_size_mask = 32'h0000_FFFF;
            end
            SIZE_W: begin
                o_be        = 4'b1111;
                w_size_mask = 32'hFFFF_FFFF;
            end
            default: ;
        endcase
    end

    // Lanes without an enable are driven to zero rather than left as stale data
    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_lane_mask[8*g +: 8] = {8{o_be[g]}};
    end

    assign o_wdata = (i_wdata << w_shamt) & w_lane_mask;
    assign o_rdata = (i_rdata >> w_shamt) & w_size_mask;

endmodule
`default_nettype wire

// File: rtl/obi_mgr_be.sv
`default_nettype none
// ============================================================================
// Module   : obi_mgr_be
// Brief    : Single-outstanding byte-enabled OBI manager with local alignment
//            checking and an optional response timeout
// Revision : 1.0
// ============================================================================
module obi_mgr_be
    import obi_mgr_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [1:0]              cmd_size_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    output logic                    obi_rready_o,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    input  logic                    obi_err_i
);

    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = {c_cnt_w{1'b1}};

    mgr_state_e              r_state;
    logic                    r_cmd_ready;
    logic                    r_req;
    logic                    r_rready;
    logic                    r_rsp_valid;
    logic                    r_rsp_err;
    logic                    r_we;
    logic [1:0]              r_size;
    logic [1:0]              r_off;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [3:0]              r_be;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rdata;
    logic [c_cnt_w-1:0]      r_cnt;

    logic [1:0]              w_size;
    logic [1:0]              w_off;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata;
    logic [31:0]             w_rdata;

    // The aligner sees the incoming command while idle and the held one afterwards
    assign w_size = (r_state == IDLE) ? cmd_size_i       : r_size;
    assign w_off  = (r_state == IDLE) ? cmd_addr_i[1:0]  : r_off;

    obi_be_align u_align (
        .i_size  (w_size),
        .i_off   (w_off),
        .i_wdata (cmd_wdata_i),
        .i_rdata (obi_rdata_i),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_req       <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_off       <= 2'b00;
            r_addr      <= '0;
            r_be        <= 4'b0000;
            r_wdata     <= 32'h0;
            r_rdata     <= 32'h0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_cmd_ready <= 1'b0;
                        r_we        <= cmd_we_i;
                        r_size      <= cmd_size_i;
                        r_off       <= cmd_addr_i[1:0];
                        r_addr      <= {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        r_be        <= w_be;
                        r_wdata     <= w_wdata;
                        if (is_aligned(cmd_size_i, cmd_addr_i[1:0])) begin
                            r_req   <= 1'b1;
                            r_state <= ADDR;
                        end else begin
                            r_state <= ERR;
                        end
                    end
                end
                ADDR: begin
                    if (obi_gnt_i) begin
                        r_req    <= 1'b0;
                        r_rready <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    if (obi_rvalid_i) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= obi_err_i;
                        r_rdata     <= (r_we || obi_err_i) ? 32'h0 : w_rdata;
                        r_state     <= DONE;
                    end else if ((TIMEOUT != 0) && (r_cnt == c_cnt_last)) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rdata     <= 32'h0;
                        r_state     <= DONE;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ERR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                    r_rdata     <= 32'h0;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rdata     <= 32'h0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_req       <= 1'b0;
                    r_rready    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o  = r_cmd_ready;
    assign obi_req_o    = r_req;
    assign obi_addr_o   = r_addr;
    assign obi_we_o     = r_we;
    assign obi_be_o     = r_be;
    assign obi_wdata_o  = r_wdata;
    assign obi_rready_o = r_rready;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_err_o    = r_rsp_err;
    assign rsp_rdata_o  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_obi_mgr_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_mgr_be
// Brief    : Self-checking bench for obi_mgr_be with a byte-level memory model
// Revision : 1.0
// ============================================================================
module tb_obi_mgr_be;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [1:0]  cmd_size_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic        obi_rready_o;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    obi_mgr_be #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_size_i   (cmd_size_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rready_o (obi_rready_o),
        .obi_rdata_i  (obi_rdata_i),
        .obi_err_i    (obi_err_i)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ref_mem   [0:63];
    logic [7:0]  slave_mem [0:63];
    logic [31:0] cap_addr, cap_wdata, cap_rdata;
    logic [3:0]  cap_be;
    logic        cap_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_f(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd0) || (size == 2'd1 && off[0] == 1'b0) || (size == 2'd2 && off == 2'd0);
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        int o;
        o  = int'(off);
        be = 4'b0000;
        for (int i = 0; i < 4; i++)
            be[i] = (i >= o) && (i < o + nbytes(size));
        return be;
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [1:0] off, input logic [31:0] wd);
        logic [31:0] r;
        logic [3:0]  be;
        int o;
        o  = int'(off);
        be = be_f(size, off);
        r  = 32'h0;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*(i-o) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] r;
        int a;
        a = int'(addr[5:0]);
        r = 32'h0;
        for (int k = 0; k < nbytes(size); k++) r[8*k +: 8] = ref_mem[a+k];
        return r;
    endfunction

    function automatic logic [31:0] slave_word(input logic [31:0] addr);
        logic [31:0] r;
        int b;
        b = int'({addr[5:2], 2'b00});
        for (int i = 0; i < 4; i++) r[8*i +: 8] = slave_mem[b+i];
        return r;
    endfunction

    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                          input int rdy_dly, input bit inj_err, input bit no_rv);
        bit          legal, eerr;
        logic [3:0]  ebe;
        logic [31:0] ewd, erd, eaddr;
        int          lim, b;
        legal = legal_f(size, addr[1:0]);
        ebe   = be_f(size, addr[1:0]);
        ewd   = wdata_f(size, addr[1:0], wd);
        eaddr = {addr[31:2], 2'b00};
        eerr  = !legal || no_rv || inj_err;
        erd   = (eerr || we) ? 32'h0 : ref_read(addr, size);
        cap_be = 4'b0; cap_wdata = 32'h0; cap_addr = 32'h0;

        chk("idle_cmd_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_size_i = size; cmd_wdata_i = wd;
        @(negedge clk_i);
        cmd_valid_i = 1'b0; cmd_addr_i = $urandom; cmd_wdata_i = $urandom; cmd_size_i = 2'($urandom);
        chk("busy_cmd_ready", cmd_ready_o, 0);

        if (!legal) begin
            chk("err_no_req", obi_req_o, 0);
            chk("err_no_rsp_yet", rsp_valid_o, 0);
            @(negedge clk_i);
        end else begin
            for (int c = 0; c <= gnt_dly; c++) begin
                chk("addr_req", obi_req_o, 1);
                chk("addr_addr", obi_addr_o, eaddr);
                chk("addr_we", obi_we_o, we);
                chk("addr_be", obi_be_o, ebe);
                chk("addr_wdata", obi_wdata_o, ewd);
                chk("addr_no_rsp", rsp_valid_o, 0);
                if (c == 0) begin
                    cap_addr = obi_addr_o; cap_be = obi_be_o; cap_wdata = obi_wdata_o;
                end
                obi_gnt_i = (c == gnt_dly);
                if (c == gnt_dly && we && !inj_err) begin
                    b = int'({obi_addr_o[5:2], 2'b00});
                    for (int i = 0; i < 4; i++)
                        if (obi_be_o[i]) slave_mem[b+i] = obi_wdata_o[8*i +: 8];
                end
                @(negedge clk_i);
            end
            obi_gnt_i = 1'b0;
            lim = no_rv ? 4 : rv_dly + 1;
            for (int c = 0; c < lim; c++) begin
                chk("resp_rready", obi_rready_o, 1);
                chk("resp_no_req", obi_req_o, 0);
                chk("resp_no_rsp", rsp_valid_o, 0);
                if (!no_rv && c == rv_dly) begin
                    obi_rvalid_i = 1'b1;
                    obi_err_i    = inj_err;
                    obi_rdata_i  = (we || inj_err) ? $urandom : slave_word(eaddr);
                end
                @(negedge clk_i);
                obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = $urandom;
            end
        end

        for (int c = 0; c <= rdy_dly; c++) begin
            chk("done_valid", rsp_valid_o, 1);
            chk("done_err", rsp_err_o, eerr);
            chk("done_rdata", rsp_rdata_o, erd);
            chk("done_cmd_ready", cmd_ready_o, 0);
            chk("done_no_req", obi_req_o, 0);
            if (c == 0) begin
                cap_rdata = rsp_rdata_o; cap_err = rsp_err_o;
                obi_rvalid_i = 1'b1; obi_rdata_i = $urandom; obi_err_i = ~eerr;
            end
            rsp_ready_i = (c == rdy_dly);
            @(negedge clk_i);
            rsp_ready_i = 1'b0; obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
        end
        chk("after_rsp_valid", rsp_valid_o, 0);
        chk("after_cmd_ready", cmd_ready_o, 1);

        if (legal && we && !inj_err)
            for (int k = 0; k < nbytes(size); k++) ref_mem[int'(addr[5:0]) + k] = wd[8*k +: 8];
    endtask

    // Protocol watcher: an ungranted request must persist unchanged
    logic        p_rst = 1'b1, p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
    logic [3:0]  p_be = 4'h0;
    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (!p_rst && p_req && !p_gnt) begin
                chk("hold_req", obi_req_o, 1);
                chk("hold_addr", obi_addr_o, p_addr);
                chk("hold_be", obi_be_o, p_be);
                chk("hold_wdata", obi_wdata_o, p_wdata);
                chk("hold_we", obi_we_o, p_we);
            end
            if (!p_rst && !reset_i)
                chk("ready_excl", cmd_ready_o && (obi_req_o || rsp_valid_o || obi_rready_o), 0);
            p_rst = reset_i; p_req = obi_req_o; p_gnt = obi_gnt_i; p_we = obi_we_o;
            p_addr = obi_addr_o; p_be = obi_be_o; p_wdata = obi_wdata_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = 32'h0;
        cmd_size_i = 2'd0; cmd_wdata_i = 32'h0; rsp_ready_i = 1'b0; obi_gnt_i = 1'b0;
        obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0; obi_err_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]   = 8'($urandom);
            slave_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk_i);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_req", obi_req_o, 0);
        chk("rst_rready", obi_rready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_rdata", rsp_rdata_o, 0);
        chk("rst_obi_fields", {obi_addr_o, obi_be_o, obi_wdata_o, obi_we_o}, 0);
        reset_i = 1'b0;
        @(negedge clk_i);

        do_txn(1'b1, 32'h10, 2'd2, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, 1'b0);
        chk("lit_word_be", cap_be, 4'b1111);
        chk("lit_word_wdata", cap_wdata, 32'hDEAD_BEEF);
        do_txn(1'b0, 32'h10, 2'd2, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        chk("lit_word_rdata", cap_rdata, 32'hDEAD_BEEF);
        chk("lit_word_err", cap_err, 0);

        do_txn(1'b1, 32'h13, 2'd0, 32'h0000_005A, 0, 0, 0, 1'b0, 1'b0);
        chk("lit_byte_be", cap_be, 4'b1000);
        chk("lit_byte_wdata", cap_wdata, 32'h5A00_0000);
        chk("lit_byte_addr", cap_addr, 32'h10);
        do_txn(1'b0, 32'h13, 2'd0, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        chk("lit_byte_rdata", cap_rdata, 32'h0000_005A);

        do_txn(1'b0, 32'h11, 2'd1, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        chk("lit_mis_half_err", cap_err, 1);
        chk("lit_mis_half_rdata", cap_rdata, 0);
        do_txn(1'b0, 32'h02, 2'd2, 32'h0, 0, 0, 0, 1'b0, 1'b0);
        chk("lit_mis_word_err", cap_err, 1);
        do_txn(1'b1, 32'h20, 2'd3, 32'h1234_5678, 0, 0, 0, 1'b0, 1'b0);
        chk("lit_rsv_err", cap_err, 1);

        do_txn(1'b1, 32'h0000_0106, 2'd1, 32'h0000_A5C3, 5, 1, 0, 1'b0, 1'b0);
        chk("lit_half_hi_be", cap_be, 4'b1100);
        chk("lit_half_hi_wdata", cap_wdata, 32'hA5C3_0000);

        do_txn(1'b0, 32'h24, 2'd2, 32'h0, 0, 0, 1, 1'b0, 1'b1);
        chk("lit_timeout_err", cap_err, 1);
        chk("lit_timeout_rdata", cap_rdata, 0);
        do_txn(1'b0, 32'h28, 2'd2, 32'h0, 1, 3, 3, 1'b0, 1'b0);
        do_txn(1'b0, 32'h2C, 2'd2, 32'h0, 0, 0, 0, 1'b1, 1'b0);
        chk("lit_obi_err", cap_err, 1);

        // Reset while the request is pending, then a stray rvalid
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h30; cmd_size_i = 2'd2;
        cmd_wdata_i = $urandom;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("rst_mid_pre_req", obi_req_o, 1);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        chk("rst_mid_req", obi_req_o, 0);
        chk("rst_mid_cmd_ready", cmd_ready_o, 1);
        chk("rst_mid_rsp_valid", rsp_valid_o, 0);
        obi_rvalid_i = 1'b1; obi_rdata_i = $urandom; obi_err_i = 1'b1;
        @(negedge clk_i);
        obi_rvalid_i = 1'b0; obi_err_i = 1'b0;
        chk("stray_rvalid_rsp", rsp_valid_o, 0);
        chk("stray_rvalid_ready", cmd_ready_o, 1);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_txn(1'($urandom), a, 2'($urandom_range(0, 3)), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
